// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Constants shared by the ALU adder/subtractor slice.
//                ALU_MODE_ADD / ALU_MODE_SUB encode the mode input.
//                ALU_WIDTH is the default operand width.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic ALU_MODE_ADD = 1'b0;
    localparam logic ALU_MODE_SUB = 1'b1;
    localparam int   ALU_WIDTH    = 4;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/adder_4bit_if.sv
`default_nettype none
// ============================================================================
//  Module      : adder_4bit_if
//  Description : Operand/result bundle for the registered adder/subtractor.
//                master : drives a, b, cin, mode, in_valid.
//                         Receives s, cout, overflow, zero, negative,
//                         out_valid.
//                slave  : the adder side, with the directions reversed.
//  Revision    : 1.0 - initial release
// ============================================================================
interface adder_4bit_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             mode;
    logic             in_valid;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             overflow;
    logic             zero;
    logic             negative;
    logic             out_valid;

    modport master (
        output a, b, cin, mode, in_valid,
        input  s, cout, overflow, zero, negative, out_valid
    );

    modport slave (
        input  a, b, cin, mode, in_valid,
        output s, cout, overflow, zero, negative, out_valid
    );
endinterface : adder_4bit_if
`default_nettype wire

// File: rtl/adder_4bit_full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder
//  Description : One-bit full adder; one stage of the ripple chain.
//                Inputs  : a, b, cin
//                Outputs : s    (sum bit)
//                          cout (carry to the next stage)
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  wire logic a,
    input  wire logic b,
    input  wire logic cin,
    output logic      s,
    output logic      cout
);
    logic w_p;

    assign w_p  = a ^ b;
    assign s    = w_p ^ cin;
    assign cout = (a & b) | (cin & w_p);
endmodule : full_adder
`default_nettype wire

// File: rtl/adder_4bit.sv
`default_nettype none
// ============================================================================
//  Module      : adder_4bit
//  Description : Registered ripple-carry adder/subtractor (ALU slice).
//                The sum is a + (b ^ {WIDTH{mode}}) + cin. The sum, carry-out
//                and the flags are registered when in_valid is high.
//                out_valid follows in_valid with one cycle of latency.
//                Ports   : clk  - rising-edge clock
//                          rst  - asynchronous, active-high reset
//                          bus  - adder_4bit_if.slave: operands and results
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_4bit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  wire logic    clk,
    input  wire logic    rst,
    adder_4bit_if.slave  bus
);
    logic [WIDTH-1:0] w_bx;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   w_carry;
    logic             w_overflow;

    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_overflow;
    logic             r_zero;
    logic             r_negative;
    logic             r_out_valid;

    // Subtraction is a + ~b + cin. The caller supplies cin=1 for a true
    // two's-complement subtract. The carry-in is never forced here.
    assign w_bx       = (bus.mode == ALU_MODE_SUB) ? ~bus.b : bus.b;
    assign w_carry[0] = bus.cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        full_adder u_fa (
            .a    (bus.a[i]),
            .b    (w_bx[i]),
            .cin  (w_carry[i]),
            .s    (w_sum[i]),
            .cout (w_carry[i+1])
        );
    end

    // Signed overflow: the carry into the MSB differs from the carry out of it.
    assign w_overflow = w_carry[WIDTH] ^ w_carry[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s         <= '0;
            r_cout      <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b1;    // keeps the reset state consistent with s == 0
            r_negative  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s        <= w_sum;
                r_cout     <= w_carry[WIDTH];
                r_overflow <= w_overflow;
                r_zero     <= (w_sum == '0);
                r_negative <= w_sum[WIDTH-1];
            end
        end
    end

    assign bus.s         = r_s;
    assign bus.cout      = r_cout;
    assign bus.overflow  = r_overflow;
    assign bus.zero      = r_zero;
    assign bus.negative  = r_negative;
    assign bus.out_valid = r_out_valid;
endmodule : adder_4bit
`default_nettype wire

// File: tb/tb_adder_4bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_4bit
//  Description : Self-checking bench for adder_4bit. A reference model pushes
//                the expected output registers into a queue for each driven
//                step. After the active edge the bench pops an entry and
//                compares it with the DUT outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_4bit;
    import alu_pkg::*;

    localparam int c_width = 4;

    typedef struct {
        logic [c_width-1:0] s;
        logic               cout;
        logic               ov;
        logic               zero;
        logic               neg;
        logic               vld;
    } exp_t;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    exp_t r_model;
    exp_t q_exp[$];

    adder_4bit_if #(.WIDTH(c_width)) bus ();

    adder_4bit #(.WIDTH(c_width)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".s"},         32'(bus.s),         32'(e.s));
        chk({tag, ".cout"},      32'(bus.cout),      32'(e.cout));
        chk({tag, ".overflow"},  32'(bus.overflow),  32'(e.ov));
        chk({tag, ".zero"},      32'(bus.zero),      32'(e.zero));
        chk({tag, ".negative"},  32'(bus.negative),  32'(e.neg));
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(e.vld));
    endtask

    function automatic exp_t reset_state();
        exp_t e;
        e.s = '0; e.cout = 1'b0; e.ov = 1'b0; e.zero = 1'b1; e.neg = 1'b0; e.vld = 1'b0;
        return e;
    endfunction

    // Drive one vector at the falling edge and push the model's register
    // image. After the next rising edge, pop the image and compare it.
    task automatic step(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                        input logic tc, input logic tm, input logic tv);
        logic [3:0] bx;
        logic [4:0] full;
        exp_t       e;
        @(negedge clk);
        bus.a = ta; bus.b = tb; bus.cin = tc; bus.mode = tm; bus.in_valid = tv;
        r_model.vld = tv;
        if (tv) begin
            bx           = tm ? ~tb : tb;
            full         = {1'b0, ta} + {1'b0, bx} + {4'b0, tc};
            r_model.s    = full[3:0];
            r_model.cout = full[4];
            r_model.ov   = (ta[3] == bx[3]) && (full[3] != ta[3]);
            r_model.zero = (full[3:0] == 4'h0);
            r_model.neg  = full[3];
        end
        q_exp.push_back(r_model);
        @(posedge clk);
        #1;
        n_assert++;
        assert (q_exp.size() > 0) else begin
            n_fail++;
            $error("FAIL %s.queue observed=empty expected=entry", tag);
        end
        if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            chk_all(tag, e);
        end
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        n_assert = 0;
        n_fail   = 0;
        r_model  = reset_state();
        rst = 1'b1;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.mode = ALU_MODE_ADD; bus.in_valid = 1'b0;
        #2;
        chk_all("reset_init", reset_state());
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Subtract set
        step("sub_1_2", 4'h1, 4'h2, 1'b1, ALU_MODE_SUB, 1'b1);
        chk("sub_1_2.s_const", 32'(bus.s), 32'h0000000F);
        step("sub_2_1", 4'h2, 4'h1, 1'b1, ALU_MODE_SUB, 1'b1);
        step("sub_7_7", 4'h7, 4'h7, 1'b1, ALU_MODE_SUB, 1'b1);
        chk("sub_7_7.zero_const", 32'(bus.zero), 32'h1);

        // Add set
        step("add_1_1", 4'h1, 4'h1, 1'b0, ALU_MODE_ADD, 1'b1);
        chk("add_1_1.s_const", 32'(bus.s), 32'h2);
        step("add_2_1", 4'h2, 4'h1, 1'b0, ALU_MODE_ADD, 1'b1);

        // Overflow / carry corners
        step("add_7_1", 4'h7, 4'h1, 1'b0, ALU_MODE_ADD, 1'b1);
        chk("add_7_1.ov_const", 32'(bus.overflow), 32'h1);
        step("add_F_1", 4'hF, 4'h1, 1'b0, ALU_MODE_ADD, 1'b1);
        step("sub_8_1", 4'h8, 4'h1, 1'b1, ALU_MODE_SUB, 1'b1);
        chk("sub_8_1.s_const", 32'(bus.s), 32'h7);
        step("add_F_F_c", 4'hF, 4'hF, 1'b1, ALU_MODE_ADD, 1'b1);
        step("sub_nocin", 4'h5, 4'h2, 1'b0, ALU_MODE_SUB, 1'b1);
        chk("sub_nocin.s_const", 32'(bus.s), 32'h2);

        // Hold with in_valid low, then resume
        step("hold_1", 4'h3, 4'h3, 1'b0, ALU_MODE_ADD, 1'b0);
        step("hold_2", 4'h9, 4'h4, 1'b1, ALU_MODE_SUB, 1'b0);
        step("resume", 4'h4, 4'h4, 1'b0, ALU_MODE_ADD, 1'b1);
        step("b2b_1", 4'h6, 4'h5, 1'b0, ALU_MODE_ADD, 1'b1);
        step("b2b_2", 4'hA, 4'h3, 1'b1, ALU_MODE_SUB, 1'b1);

        // Asynchronous reset in mid-cycle, with an operation in flight
        @(negedge clk);
        bus.a = 4'h5; bus.b = 4'h6; bus.cin = 1'b0; bus.mode = ALU_MODE_ADD; bus.in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        r_model = reset_state();
        chk_all("reset_async", r_model);
        @(posedge clk);
        #1;
        chk_all("reset_hold", r_model);
        @(negedge clk);
        rst = 1'b0;
        step("post_reset", 4'h3, 4'h4, 1'b0, ALU_MODE_ADD, 1'b1);

        // Exhaustive sweep
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < 2; c++)
                for (int ia = 0; ia < 16; ia++)
                    for (int ib = 0; ib < 16; ib++)
                        step("sweep", 4'(ia), 4'(ib), 1'(c), 1'(m), 1'b1);

        // Randomised vectors with gaps in in_valid
        for (int k = 0; k < 64; k++)
            step("rand", 4'($urandom_range(15)), 4'($urandom_range(15)),
                 1'($urandom_range(1)), 1'($urandom_range(1)),
                 ($urandom_range(3) != 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule : tb_adder_4bit
`default_nettype wire

// File: doc/adder_4bit.md
Name: adder_4bit

Overview:
Registered ripple-carry adder/subtractor for the ALU datapath.
- mode=0 adds; mode=1 subtracts using two's complement: b is inverted, and the caller drives cin=1.
- Result, carry-out and status flags are captured on the clock edge. The ALU result mux reads them one cycle after the operands are presented.

Parameters:
- WIDTH, 4, operand and result width in bits; must be ≥1. Default instance is the 4-bit ALU slice.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- a  input  WIDTH  operand A, unsigned or two's-complement
- b  input  WIDTH  operand B
- cin  input  1  carry-in; caller drives 1 for subtraction, 0 for plain add
- mode  input  1  0 = add, 1 = subtract (invert b)
- in_valid  input  1  operands valid this cycle
- s  output  WIDTH  registered sum/difference
- cout  output  1  registered carry-out of the MSB (no-borrow flag when subtracting)
- overflow  output  1  registered signed overflow
- zero  output  1  registered s == 0
- negative  output  1  registered s[WIDTH-1]
- out_valid  output  1  registered in_valid

Behaviour:
- Combinational core: bx = b XOR {WIDTH{mode}}; {c, sum} = a + bx + cin, computed as a WIDTH-stage ripple chain.
- cin is used exactly as supplied; mode does not force the carry-in.
  - mode=1, cin=0 yields a - b - 1, which is a legal, defined result.
- overflow = carry into MSB XOR carry out of MSB.
- zero = (sum == 0); negative = sum[WIDTH-1].
- Register stage: on rising clk with in_valid=1, s, cout, overflow, zero and negative load the combinational values.
  - With in_valid=0, those registers hold their previous values.
  - out_valid loads in_valid every cycle.
- Latency: exactly 1 cycle from operands to outputs; throughput 1 operation per cycle; no backpressure.
- Reset: while rst=1, all outputs are 0 immediately, independent of clk, and stay 0.
  - Exception: zero is 1 during reset, consistent with s=0.
- Reset mid-operation: an operation in flight is discarded. The first edge after rst falls captures current inputs normally.
- Wrap-around: the result is modulo 2^WIDTH, with the carry reported only in cout.
- Subtract semantics (mode=1, cin=1): cout=1 means a ≥ b unsigned (no borrow); cout=0 means borrow.
- No X propagation when inputs are known; there are no internal states other than the output registers.

Decomposition:
- Shared package alu_pkg:
  - constant ALU_MODE_ADD=1'b0, ALU_MODE_SUB=1'b1;
  - default width constant ALU_WIDTH=4.
- Sub-module full_adder (a, b, cin -> s, cout), instantiated WIDTH times in a generate loop to form the ripple chain.
- Flag logic and the output register live in adder_4bit.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> s=0, cout=0, overflow=0, negative=0, zero=1, out_valid=0 immediately, with no clock edge.
- Subtract set (mode=1, cin=1, in_valid=1), one vector per cycle:
  - a=1, b=2 -> s=4'hF, cout=0, negative=1, overflow=0
  - a=2, b=1 -> s=4'h1, cout=1
  - a=7, b=7 -> s=4'h0, cout=1, zero=1
- Add set (mode=0, cin=0):
  - a=1, b=1 -> s=4'h2, cout=0
  - a=2, b=1 -> s=4'h3, cout=0
  - each appears one cycle after its operands.
- Overflow/carry corners:
  - add a=7, b=1 -> s=8, overflow=1, negative=1
  - add a=F, b=1 -> s=0, cout=1, zero=1
  - sub a=8, b=1, cin=1 -> s=7, overflow=1, cout=1
  - add with cin=1, a=F, b=F -> s=F, cout=1
- Hold and valid: drive a new vector with in_valid=0 -> s and flags unchanged, out_valid=0 the next cycle.
  - Re-assert in_valid -> update with 1-cycle latency.
  - Back-to-back vectors produce one result per cycle.
- Exhaustive randomized sweep: all a, b, cin, mode combinations against the reference formula {cout, s} = a + (b XOR {4{mode}}) + cin, including the flags.
